bus_responder: RTL and testbench
================================

# bus_responder

Memory-mapped responder on the processor's data bus. It decodes the address the controller drives and returns read data on DIN with fixed one-cycle latency. It serves four regions: a word RAM, an LED output register, a synchronised switch input, and a small transmit queue with a valid/ready drain port. It sits between the processor datapath (ADDR/DOUT/W outputs) and board-level I/O.

## Interface
Parameters:
- DATA_W, 9, bus data width
- ADDR_W, 9, bus address width; region select is ADDR[ADDR_W-1:ADDR_W-2]
- RAM_DEPTH, 128, RAM words; index is ADDR[6:0]
- TXQ_DEPTH, 4, transmit queue entries (power of two)

Ports:
- Single clock CLK. Reset RST is asynchronous and active-low.
- CLK  in  1  clock
- RST  in  1  asynchronous active-low reset
- ADDR  in  ADDR_W  address from processor address register
- DOUT  in  DATA_W  write data from processor
- W  in  1  write strobe, sampled at rising CLK
- DIN  out  DATA_W  registered read data to processor
- SW  in  DATA_W  asynchronous switch inputs
- LEDR  out  DATA_W  LED register
- TXQ_DATA  out  DATA_W  head of transmit queue
- TXQ_VALID  out  1  queue non-empty
- TXQ_READY  in  1  consumer accepts head this cycle

## Operation
- Region decode on ADDR[8:7]:
  - 00: RAM[ADDR[6:0]]
  - 01: LED register
  - 10: switch register (read-only; writes ignored)
  - 11: transmit queue
- Read: every cycle DIN is loaded with the data of the region addressed at that edge. No read strobe exists.
  - RAM, LED and SW regions return their stored value.
  - Queue region returns {overflow, 4'b0, count[3:0]}, zero-extended to DATA_W.
- Write: at a rising edge with W=1, DOUT goes to the addressed region.
  - RAM: stores the word.
  - LED: LEDR <= DOUT.
  - SW: ignored.
  - Queue: push.
- Same-cycle read and write to the same RAM or LED location: DIN returns the old value (read-before-write).
- Switch register: two-flop synchroniser on SW. Reads see the second stage.
- Transmit queue:
  - Circular buffer with rd/wr pointers and a count of 0..TXQ_DEPTH.
  - Pop occurs when TXQ_VALID & TXQ_READY.
  - A push is accepted if count<TXQ_DEPTH, or if a pop occurs in the same cycle. A push while full without a pop is dropped and sets the sticky overflow flag.
  - Simultaneous push and pop: count is unchanged and both pointers advance.
  - Pointers wrap modulo TXQ_DEPTH.
  - A read of the queue region (ADDR[8:7]=11 with W=0) clears overflow at that edge. DIN still captures the pre-clear value.
  - If a set and a clear happen in the same cycle, set wins.
- TXQ_DATA = storage[rd_ptr] and TXQ_VALID = (count!=0), both from registers. The data is stable while VALID is high and READY is low.

## Timing
- Reset values: DIN=0, LEDR=0, TXQ_VALID=0, TXQ_DATA=0, overflow=0, count=0, pointers=0, synchroniser flops=0.
- RAM contents are not reset and are undefined until written.
- Read latency is 1 cycle. ADDR presented at edge N produces valid DIN after edge N, usable by the processor at edge N+1. This matches the controller's address-then-wait sequencing.
- Write takes effect at the edge where W=1. A read of the same location at the next edge returns the new value.
- Push to an empty queue: TXQ_VALID goes high after the push edge, and the consumer can pop at the following edge.
- SW change to visible DIN: 3 edges (2 synchroniser edges plus 1 read edge).
- Reset asserted mid-operation:
  - All registers clear immediately and asynchronously.
  - Queued entries are lost and TXQ_VALID drops without a pop.
  - A write in progress at that edge is not performed.

## Structure
- Package bus_resp_pkg holds:
  - region enum (REG_RAM=2'b00, REG_LED=2'b01, REG_SW=2'b10, REG_TXQ=2'b11)
  - default width and depth constants
  - the bit position of the overflow flag in the status word
- Sub-module tx_fifo (parameterised on DATA_W and TXQ_DEPTH): push/pop, count, overflow, head outputs.
- The top level holds the decode, RAM array, LED register, synchroniser and DIN mux register.

## Test plan
- Reset, then write 9'h1A5 to addr 9'h005 and read addr 9'h005 → DIN=9'h1A5 one cycle after the read address. DIN=0 during reset.
- Same edge: W=1 to addr 9'h005 with DOUT=9'h033, while the previous value is 9'h1A5 → DIN=9'h1A5 at that edge. A read on the next cycle returns 9'h033.
- Write 9'h0F0 to 9'h080 → LEDR=9'h0F0. Write to 9'h100 → no effect. SW=9'h155 → reading 9'h100 gives 9'h155 within 3 edges.
- TXQ_READY=0; push 5 words 1..5 to 9'h180 → status read = 9'h104 (overflow=1, count=4), word 5 dropped. A second status read → 9'h004.
- Full queue, push 9'h0AA with TXQ_READY=1 on the same edge → word 1 popped, 9'h0AA accepted, count stays 4. Draining yields 2,3,4,0AA, then TXQ_VALID=0.
- Queue holding 2 entries, assert RST low between edges → TXQ_VALID=0, LEDR=0 and DIN=0 immediately. After release, status read = 9'h000.

Source files
------------

// File: rtl/bus_resp_pkg.sv
// bus_resp_pkg: shared region codes, default geometry and status-word layout
// for the bus_responder slice. Imported by bus_responder and tx_fifo.
// Contents: region_e enum, DEF_* size constants, STAT_* status field positions.
package bus_resp_pkg;

  // Region select taken from the two MSBs of the bus address.
  typedef enum logic [1:0] {
    REG_RAM = 2'b00,
    REG_LED = 2'b01,
    REG_SW  = 2'b10,
    REG_TXQ = 2'b11
  } region_e;

  localparam int DEF_DATA_W    = 9;
  localparam int DEF_ADDR_W    = 9;
  localparam int DEF_RAM_DEPTH = 128;
  localparam int DEF_TXQ_DEPTH = 4;

  // Queue status word: {overflow, 4'b0, count[3:0]}.
  localparam int STAT_OVF_BIT = 8;
  localparam int STAT_CNT_W   = 4;

endpackage : bus_resp_pkg

// File: rtl/tx_fifo.sv
// tx_fifo: circular transmit queue with sticky overflow flag.
// Latency: push visible on head/valid after the push edge; pop at the edge where valid & ready.
// Backpressure: push while full is dropped (sets overflow) unless a pop happens on the same edge.
// Ports: clk_i/rst_ni, push_i/push_dat_i (write side), ready_i (drain side),
//        clr_ovf_i (status read), head_o/valid_o (drain), count_o/ovf_o (status).
module tx_fifo
  import bus_resp_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int TXQ_DEPTH = DEF_TXQ_DEPTH,
  parameter int PTR_W     = (TXQ_DEPTH > 1) ? $clog2(TXQ_DEPTH) : 1,
  parameter int CNT_W     = $clog2(TXQ_DEPTH + 1)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              push_i,
  input  logic [DATA_W-1:0] push_dat_i,
  input  logic              ready_i,
  input  logic              clr_ovf_i,
  output logic [DATA_W-1:0] head_o,
  output logic              valid_o,
  output logic [CNT_W-1:0]  count_o,
  output logic              ovf_o
);

  logic [DATA_W-1:0] storage_q [TXQ_DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              ovf_q, ovf_d;

  logic pop;
  logic full;
  logic push_ok;
  logic drop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(TXQ_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign valid_o = (count_q != '0);
  assign pop     = valid_o & ready_i;
  assign full    = (count_q == CNT_W'(TXQ_DEPTH));
  // A full queue still takes a push when the head leaves on the same edge.
  assign push_ok = push_i & (~full | pop);
  assign drop    = push_i & full & ~pop;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;

    if (pop)     rd_ptr_d = ptr_inc(rd_ptr_q);
    if (push_ok) wr_ptr_d = ptr_inc(wr_ptr_q);

    if (push_ok && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push_ok) count_d = count_q - 1'b1;

    // Set has priority over a same-edge clear so a drop is never lost.
    if (drop)           ovf_d = 1'b1;
    else if (clr_ovf_i) ovf_d = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      for (int i = 0; i < TXQ_DEPTH; i++) storage_q[i] <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      if (push_ok) storage_q[wr_ptr_q] <= push_dat_i;
    end
  end

  assign head_o  = storage_q[rd_ptr_q];
  assign count_o = count_q;
  assign ovf_o   = ovf_q;

endmodule : tx_fifo

// File: rtl/bus_responder.sv
// bus_responder: memory-mapped responder (RAM, LED reg, synced switches, TX queue).
// Latency: DIN registered, one cycle after ADDR; writes land at the W edge; SW->DIN 3 edges.
// Backpressure: TXQ drains via TXQ_VALID/TXQ_READY; pushes into a full queue drop and flag overflow.
// Ports: CLK/RST (async active-low), ADDR/DOUT/W from the processor, DIN read data,
//        SW switch inputs, LEDR LED register, TXQ_DATA/TXQ_VALID/TXQ_READY drain port.
module bus_responder
  import bus_resp_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int RAM_DEPTH = DEF_RAM_DEPTH,
  parameter int TXQ_DEPTH = DEF_TXQ_DEPTH
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [ADDR_W-1:0] ADDR,
  input  logic [DATA_W-1:0] DOUT,
  input  logic              W,
  output logic [DATA_W-1:0] DIN,
  input  logic [DATA_W-1:0] SW,
  output logic [DATA_W-1:0] LEDR,
  output logic [DATA_W-1:0] TXQ_DATA,
  output logic              TXQ_VALID,
  input  logic              TXQ_READY
);

  localparam int RAM_AW = $clog2(RAM_DEPTH);
  localparam int CNT_W  = $clog2(TXQ_DEPTH + 1);

  region_e            region;
  logic [RAM_AW-1:0]  ram_idx;

  logic [DATA_W-1:0]  ram_q [RAM_DEPTH];
  logic [DATA_W-1:0]  led_q, led_d;
  logic [DATA_W-1:0]  sw_meta_q;
  logic [DATA_W-1:0]  sw_sync_q;
  logic [DATA_W-1:0]  din_q, din_d;

  logic               ram_we;
  logic               txq_push;
  logic               txq_clr;
  logic [CNT_W-1:0]   txq_count;
  logic               txq_ovf;
  logic [DATA_W-1:0]  txq_status;

  assign region  = region_e'(ADDR[ADDR_W-1 -: 2]);
  assign ram_idx = ADDR[RAM_AW-1:0];

  assign ram_we   = W & (region == REG_RAM);
  assign txq_push = W & (region == REG_TXQ);
  // Any read of the queue region acknowledges the overflow flag.
  assign txq_clr  = ~W & (region == REG_TXQ);

  always_comb begin
    txq_status                         = '0;
    txq_status[STAT_OVF_BIT]           = txq_ovf;
    txq_status[STAT_CNT_W-1:0]         = STAT_CNT_W'(txq_count);
  end

  // Read mux sees pre-edge state, giving read-before-write on RAM and LED.
  always_comb begin
    din_d = '0;
    unique case (region)
      REG_RAM: din_d = ram_q[ram_idx];
      REG_LED: din_d = led_q;
      REG_SW:  din_d = sw_sync_q;
      REG_TXQ: din_d = txq_status;
      default: din_d = '0;
    endcase
  end

  always_comb begin
    led_d = led_q;
    if (W && region == REG_LED) led_d = DOUT;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      din_q     <= '0;
      led_q     <= '0;
      sw_meta_q <= '0;
      sw_sync_q <= '0;
    end else begin
      din_q     <= din_d;
      led_q     <= led_d;
      sw_meta_q <= SW;
      sw_sync_q <= sw_meta_q;
    end
  end

  // RAM contents are intentionally not reset.
  always_ff @(posedge CLK) begin
    if (ram_we && RST) ram_q[ram_idx] <= DOUT;
  end

  tx_fifo #(
    .DATA_W    (DATA_W),
    .TXQ_DEPTH (TXQ_DEPTH)
  ) u_tx_fifo (
    .clk_i      (CLK),
    .rst_ni     (RST),
    .push_i     (txq_push),
    .push_dat_i (DOUT),
    .ready_i    (TXQ_READY),
    .clr_ovf_i  (txq_clr),
    .head_o     (TXQ_DATA),
    .valid_o    (TXQ_VALID),
    .count_o    (txq_count),
    .ovf_o      (txq_ovf)
  );

  assign DIN  = din_q;
  assign LEDR = led_q;

endmodule : bus_responder

// File: tb/tb_bus_responder.sv
// tb_bus_responder: directed bench for bus_responder with hand-computed expectations.
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
module tb_bus_responder;

  logic       CLK;
  logic       RST;
  logic [8:0] ADDR;
  logic [8:0] DOUT;
  logic       W;
  logic [8:0] DIN;
  logic [8:0] SW;
  logic [8:0] LEDR;
  logic [8:0] TXQ_DATA;
  logic       TXQ_VALID;
  logic       TXQ_READY;

  int total = 0;
  int bad   = 0;

  bus_responder dut (
    .CLK       (CLK),
    .RST       (RST),
    .ADDR      (ADDR),
    .DOUT      (DOUT),
    .W         (W),
    .DIN       (DIN),
    .SW        (SW),
    .LEDR      (LEDR),
    .TXQ_DATA  (TXQ_DATA),
    .TXQ_VALID (TXQ_VALID),
    .TXQ_READY (TXQ_READY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic bus(input logic [8:0] a, input logic [8:0] d, input logic w);
    ADDR = a;
    DOUT = d;
    W    = w;
  endtask

  initial begin
    RST = 1'b0; ADDR = '0; DOUT = '0; W = 1'b0; SW = '0; TXQ_READY = 1'b0;
    bus(9'h005, 9'h1FF, 1'b1);   // write attempt while held in reset
    tick(); tick();
    check("rst_din",   DIN, 9'h000);
    check("rst_ledr",  LEDR, 9'h000);
    check("rst_valid", {8'h0, TXQ_VALID}, 9'h000);
    check("rst_txqd",  TXQ_DATA, 9'h000);
    RST = 1'b1;

    // RAM write then read
    bus(9'h005, 9'h1A5, 1'b1); tick();
    bus(9'h005, 9'h000, 1'b0); tick();
    check("ram_rd", DIN, 9'h1A5);

    // Read-before-write on the same edge
    bus(9'h005, 9'h033, 1'b1); tick();
    check("ram_rbw_old", DIN, 9'h1A5);
    bus(9'h005, 9'h000, 1'b0); tick();
    check("ram_rbw_new", DIN, 9'h033);

    // Neighbouring RAM word is independent
    bus(9'h006, 9'h0C3, 1'b1); tick();
    bus(9'h006, 9'h000, 1'b0); tick();
    check("ram_rd6", DIN, 9'h0C3);
    bus(9'h005, 9'h000, 1'b0); tick();
    check("ram_rd5_kept", DIN, 9'h033);

    // LED register
    bus(9'h080, 9'h0F0, 1'b1); tick();
    check("led_wr", LEDR, 9'h0F0);
    bus(9'h080, 9'h000, 1'b0); tick();
    check("led_rd", DIN, 9'h0F0);

    // Switch region write ignored; switches reach DIN after 3 edges
    bus(9'h100, 9'h1FF, 1'b1); tick();
    check("sw_wr_led", LEDR, 9'h0F0);
    check("sw_wr_din", DIN, 9'h000);
    bus(9'h100, 9'h000, 1'b0);
    SW = 9'h155;
    tick(); tick();
    check("sw_2edges", DIN, 9'h000);
    tick();
    check("sw_3edges", DIN, 9'h155);

    // Fill queue past capacity with the consumer stalled
    TXQ_READY = 1'b0;
    bus(9'h180, 9'h001, 1'b1); tick();
    check("q_valid1", {8'h0, TXQ_VALID}, 9'h001);
    check("q_head1",  TXQ_DATA, 9'h001);
    for (int i = 2; i <= 5; i++) begin
      bus(9'h180, 9'(i), 1'b1); tick();
    end
    bus(9'h180, 9'h000, 1'b0); tick();
    check("q_stat_ovf", DIN, 9'h104);
    tick();
    check("q_stat_clr", DIN, 9'h004);
    check("q_head_stall", TXQ_DATA, 9'h001);

    // Push and pop on the same edge while full
    TXQ_READY = 1'b1;
    bus(9'h180, 9'h0AA, 1'b1); tick();
    TXQ_READY = 1'b0;
    check("q_pp_head", TXQ_DATA, 9'h002);
    bus(9'h180, 9'h000, 1'b0); tick();
    check("q_pp_stat", DIN, 9'h004);

    // Drain
    bus(9'h000, 9'h000, 1'b0);
    TXQ_READY = 1'b1;
    tick(); check("q_drain3", TXQ_DATA, 9'h003);
    tick(); check("q_drain4", TXQ_DATA, 9'h004);
    tick(); check("q_drainAA", TXQ_DATA, 9'h0AA);
    check("q_drain_v", {8'h0, TXQ_VALID}, 9'h001);
    tick(); check("q_empty_v", {8'h0, TXQ_VALID}, 9'h000);
    TXQ_READY = 1'b0;
    bus(9'h180, 9'h000, 1'b0); tick();
    check("q_empty_stat", DIN, 9'h000);

    // Asynchronous reset with two entries queued
    bus(9'h180, 9'h011, 1'b1); tick();
    bus(9'h180, 9'h022, 1'b1); tick();
    check("q_two_din", DIN, 9'h001);
    bus(9'h180, 9'h000, 1'b0); tick();
    check("q_two_stat", DIN, 9'h002);
    #2;
    RST = 1'b0;
    #1;
    check("arst_valid", {8'h0, TXQ_VALID}, 9'h000);
    check("arst_ledr",  LEDR, 9'h000);
    check("arst_din",   DIN, 9'h000);
    check("arst_txqd",  TXQ_DATA, 9'h000);
    tick();
    RST = 1'b1;
    tick();
    check("post_rst_stat", DIN, 9'h000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_bus_responder
